regfile_mp: RTL

Parametrised multi-port general-purpose register file, the successor to the single-write, two-read register file in the CPU core. It has configurable data width, depth and read-port count, and two prioritised write ports for dual-issue writeback. Same-cycle write-to-read bypass is retained. A hardware clear sequencer zeroes the whole array after reset or on request, and a registered write-conflict flag reports collisions between the two write ports. It sits between the decode stage (read ports) and the writeback stage (write ports).

---
 rtl/regfile_mp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file.
//
// Two prioritised write ports (port 1 wins on an address collision) feed a
// flop-based array. NUM_RD combinational read ports see same-cycle writes
// through a bypass. A clear sequencer zeroes the array one entry per cycle
// after reset or on request. The array is usable only while ready is high.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   clr          request to re-zero the array (honoured only when ready)
//   ready        array usable; low while the clear sequencer runs
//   we0/waddr0/wdata0  write port 0
//   we1/waddr1/wdata1  write port 1 (priority over port 0)
//   re           per-port read enable, bit i -> port i
//   raddr        packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata        packed read data, port i at [i*DATA_W +: DATA_W]
//   wr_conflict  one-cycle pulse after an edge where both ports wrote one address
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    output logic                       ready,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic                       wr_conflict
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                conflict_q, conflict_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                zero_en;
    logic                wr0_zero, wr1_zero;
    logic                wr0_en, wr1_en;
    logic                in_ready;

    assign zero_en  = (ZERO_REG != 0);
    assign in_ready = (state_q == StReady);

    // Writes aimed at the hardwired zero entry are dropped entirely.
    assign wr0_zero = zero_en && (waddr0 == '0);
    assign wr1_zero = zero_en && (waddr1 == '0);
    assign wr0_en   = in_ready && we0 && !wr0_zero;
    assign wr1_en   = in_ready && we1 && !wr1_zero;

    // ------------------------------------------------------------------
    // Control FSM and clear counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        unique case (state_q)
            StClear: begin
                if (&cnt_q) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StReady: begin
                // wr1_en already excludes the zero entry, so a dropped
                // zero-register collision never raises the flag.
                conflict_d = wr0_en && wr1_en && (waddr0 == waddr1);
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StClear;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    assign ready       = in_ready;
    assign wr_conflict = conflict_q;

    // ------------------------------------------------------------------
    // Storage array (no reset; zeroed by the clear sequencer)
    // ------------------------------------------------------------------
    // Port 1 is assigned last so it overrides port 0 on a shared address.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr0_en) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_en) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports with write-to-read bypass
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            ra = raddr[i*ADDR_W +: ADDR_W];
            rd = '0;
            if (!rst || !in_ready || !re[i]) begin
                rd = '0;
            end else if (zero_en && (ra == '0)) begin
                rd = '0;
            end else if (we1 && (ra == waddr1)) begin
                rd = wdata1;
            end else if (we0 && (ra == waddr0)) begin
                rd = wdata0;
            end else begin
                rd = mem[ra];
            end
            rdata[i*DATA_W +: DATA_W] = rd;
        end
    end

endmodule
